// File: rtl/decode_pkg.sv
// decode_pkg: opcode/funct tables, code-bit indices and entry type shared by decode_queue.
// DECODE_EXT_INSTR_EN widens the default code to 40 bits for the mult/div/hi/lo group.
package decode_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam int N_R = 17;
  localparam int N_I = 14;
  localparam int N_EXT = 8;
  localparam logic [5:0] R_FUNCT [N_R] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                          6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  localparam logic [5:0] I_OPC [N_I] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B,
                                         6'h04, 6'h05, 6'h0A, 6'h0B, 6'h0F, 6'h02, 6'h03};
  localparam logic [5:0] EXT_FUNCT [N_EXT] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13};
  localparam int CODE_ADD = 0;
  localparam int CODE_ADDI = 17;
  localparam int CODE_JAL = 30;
  localparam int CODE_MULT = 32;
`ifdef DECODE_EXT_INSTR_EN
  localparam int CODE_W_DEF = 40;
`else
  localparam int CODE_W_DEF = 32;
`endif
  localparam int PC_W_DEF = 32;
  typedef struct packed {
    logic [CODE_W_DEF-1:0] code;
    logic illegal;
    logic [31:0] instr;
    logic [PC_W_DEF-1:0] pc;
  } decode_entry_t;
endpackage

// File: rtl/decode_lut.sv
// decode_lut: combinational MIPS-32 word -> one-hot code plus illegal flag.
// DECODE_EXT_INSTR_EN enables the mult/div/hi/lo funct group on bits 32..39.
module decode_lut import decode_pkg::*; #(
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic [31:0]       instr,
  output logic [CODE_W-1:0] code,
  output logic              illegal
);
  logic [5:0] op;
  logic [5:0] fn;
  logic unused_bits;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_bits = ^instr[25:6];
  always_comb begin
    code = '0;
    for (int i = 0; i < N_R; i++)
      if (op == OP_RTYPE && fn == R_FUNCT[i]) code[CODE_ADD+i] = 1'b1;
`ifdef DECODE_EXT_INSTR_EN
    for (int i = 0; i < N_EXT; i++)
      if (op == OP_RTYPE && fn == EXT_FUNCT[i]) code[CODE_MULT+i] = 1'b1;
`endif
    for (int i = 0; i < N_I; i++)
      if (op == I_OPC[i]) code[CODE_ADDI+i] = 1'b1;
  end
  assign illegal = ~|code;
endmodule

// File: rtl/decode_queue.sv
// decode_queue: decodes instructions at push time into a DEPTH-entry FIFO with illegal counter.
// DECODE_EXT_INSTR_EN (in decode_lut) adds the mult/div/hi/lo decodes and widens CODE_W to 40.
module decode_queue import decode_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_illegal,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  illegal_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic illegal;
    logic [31:0] instr;
    logic [PC_W-1:0] pc;
  } entry_t;
  entry_t mem_q [DEPTH];
  entry_t wr_d;
  entry_t head;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CODE_W-1:0] lut_code;
  logic lut_illegal, push, pop;
  decode_lut #(.CODE_W(CODE_W)) u_lut (.instr(in_instr), .code(lut_code), .illegal(lut_illegal));
  // Occupancy comes only from count, so pointer equality never has to tell full from empty.
  always_comb begin
    in_ready = count_q < (AW+1)'(DEPTH);
    out_valid = count_q != '0;
    push = in_valid & in_ready & ~flush;
    pop = out_valid & out_ready & ~flush;
    wr_d = '{code: lut_code, illegal: lut_illegal, instr: in_instr, pc: in_pc};
    wptr_d = flush ? '0 : wptr_q + AW'(push);
    rptr_d = flush ? '0 : rptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    cnt_d = (push && lut_illegal && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    head = out_valid ? mem_q[rptr_q] : '0;
  end
  assign out_code = head.code;
  assign out_illegal = head.illegal;
  assign out_instr = head.instr;
  assign out_pc = head.pc;
  assign illegal_cnt = cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= wr_d;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed and randomized checks of decode_queue against a queue-based model.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int PC_W = 32;
  localparam int CNT_W = 2;
`ifdef DECODE_EXT_INSTR_EN
  localparam int CODE_W = 40;
`else
  localparam int CODE_W = 32;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, out_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [CODE_W-1:0] out_code;
  logic [CNT_W-1:0] illegal_cnt;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [CODE_W-1:0] code;
    logic ill;
    logic [31:0] instr;
    logic [PC_W-1:0] pc;
  } ent_t;
  ent_t q[$];
  int m_cnt = 0;
  localparam logic [5:0] RF [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                     6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  localparam logic [5:0] IO [14] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B,
                                     6'h04, 6'h05, 6'h0A, 6'h0B, 6'h0F, 6'h02, 6'h03};

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W), .CODE_W(CODE_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_illegal(out_illegal), .out_instr(out_instr), .out_pc(out_pc),
    .illegal_cnt(illegal_cnt));

  function automatic int ref_bit(logic [31:0] w);
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20: return 0;  6'h21: return 1;  6'h22: return 2;  6'h23: return 3;
        6'h24: return 4;  6'h25: return 5;  6'h26: return 6;  6'h27: return 7;
        6'h2A: return 8;  6'h2B: return 9;  6'h00: return 10; 6'h02: return 11;
        6'h03: return 12; 6'h04: return 13; 6'h06: return 14; 6'h07: return 15;
        6'h08: return 16;
`ifdef DECODE_EXT_INSTR_EN
        6'h18: return 32; 6'h19: return 33; 6'h1A: return 34; 6'h1B: return 35;
        6'h10: return 36; 6'h11: return 37; 6'h12: return 38; 6'h13: return 39;
`endif
        default: return -1;
      endcase
    end
    case (op)
      6'h08: return 17; 6'h09: return 18; 6'h0C: return 19; 6'h0D: return 20;
      6'h0E: return 21; 6'h23: return 22; 6'h2B: return 23; 6'h04: return 24;
      6'h05: return 25; 6'h0A: return 26; 6'h0B: return 27; 6'h0F: return 28;
      6'h02: return 29; 6'h03: return 30;
      default: return -1;
    endcase
  endfunction

  function automatic ent_t mk(logic [31:0] w, logic [PC_W-1:0] pc);
    ent_t e;
    int b = ref_bit(w);
    e.code = '0;
    if (b >= 0) e.code[b] = 1'b1;
    e.ill = (b < 0);
    e.instr = w;
    e.pc = pc;
    return e;
  endfunction

  function automatic ent_t head_m();
    ent_t e;
    e = '{code: '0, ill: 1'b0, instr: '0, pc: '0};
    if (q.size() != 0) e = q[0];
    return e;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 3))
      0: begin w[31:26] = 6'h00; w[5:0] = RF[$urandom_range(0, 16)]; end
      1: w[31:26] = IO[$urandom_range(0, 13)];
      2: begin w[31:26] = 6'h00; w[5:0] = 6'($urandom_range(16, 27)); end
      default: ;
    endcase
    return w;
  endfunction

  // One clock: drive at negedge, advance model at posedge, return at next negedge.
  task automatic cyc(input logic v, input logic [31:0] w, input logic [PC_W-1:0] pc,
                     input logic rdy, input logic fl);
    bit push, pop;
    ent_t e;
    in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy; flush = fl;
    e = mk(w, pc);
    push = v && q.size() < DEPTH && !fl;
    pop = q.size() != 0 && rdy && !fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    if (push && e.ill && m_cnt < CNT_MAX) m_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete(); m_cnt = 0;
    n_chk++;
    if ({out_valid, out_code, out_illegal, out_instr, out_pc, illegal_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_outs got v=%b code=%h ill=%b instr=%h pc=%h cnt=%0d want all zero",
                         out_valid, out_code, out_illegal, out_instr, out_pc, illegal_cnt);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    cyc(1'b1, 32'h00221820, 32'h100, 1'b1, 1'b0);
    n_chk++;
    if (out_valid !== 1'b1 || out_code !== CODE_W'(1) || out_illegal !== 1'b0 || out_pc !== 32'h100) begin
      n_fail++; $display("FAIL add got v=%b code=%h ill=%b pc=%h want v=1 code=1 ill=0 pc=100",
                         out_valid, out_code, out_illegal, out_pc);
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got v=%b want 0", out_valid); end
  endtask

  task automatic test_lui_illegal();
    cyc(1'b1, 32'h3C01FFFF, 32'h104, 1'b0, 1'b0);
    cyc(1'b1, 32'hFC000000, 32'h108, 1'b0, 1'b0);
    n_chk++;
    if (out_code !== CODE_W'(32'h10000000) || out_illegal !== 1'b0) begin
      n_fail++; $display("FAIL lui_code got %h ill=%b want 10000000 ill=0", out_code, out_illegal);
    end
    n_chk++;
    if (illegal_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL lui_cnt got %0d want 1", illegal_cnt); end
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    n_chk++;
    if (out_code !== '0 || out_illegal !== 1'b1 || out_instr !== 32'hFC000000) begin
      n_fail++; $display("FAIL illegal_head got code=%h ill=%b instr=%h want 0 1 fc000000",
                         out_code, out_illegal, out_instr);
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (in_ready !== (i < DEPTH)) begin
        n_fail++; $display("FAIL fill_ready[%0d] got %b want %b", i, in_ready, i < DEPTH);
      end
      cyc(1'b1, 32'h00221820 | (i << 11), PC_W'(32'h200 + 4 * i), 1'b0, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_pc !== PC_W'(32'h200 + 4 * i) || out_instr !== (32'h00221820 | (i << 11))) begin
        n_fail++; $display("FAIL drain[%0d] got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                           i, out_valid, out_pc, out_instr, 32'h200 + 4 * i, 32'h00221820 | (i << 11));
      end
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
    end
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got v=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h00221822, PC_W'(32'h300 + 4 * i), 1'b0, 1'b0);
    cyc(1'b1, 32'h3C01ABCD, 32'h3F0, 1'b1, 1'b1);
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_code !== '0) begin
      n_fail++; $display("FAIL flush got v=%b rdy=%b code=%h want 0 1 0", out_valid, in_ready, out_code);
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    n_chk++;
    if (out_valid !== 1'b0 || illegal_cnt !== CNT_W'(1)) begin
      n_fail++; $display("FAIL flush_after got v=%b cnt=%0d want v=0 cnt=1", out_valid, illegal_cnt);
    end
  endtask

  task automatic test_async_rst();
    cyc(1'b1, 32'hFC000000, 32'h500, 1'b0, 1'b0);
    cyc(1'b1, 32'h00221820, 32'h504, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || illegal_cnt !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_rst got v=%b cnt=%0d rdy=%b want 0 0 1", out_valid, illegal_cnt, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete(); m_cnt = 0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'hFC000000 | i, PC_W'(32'h600 + 4 * i), 1'b1, 1'b0);
      n_chk++;
      if (illegal_cnt !== CNT_W'(i + 1 > CNT_MAX ? CNT_MAX : i + 1)) begin
        n_fail++; $display("FAIL sat[%0d] got %0d want %0d", i, illegal_cnt, i + 1 > CNT_MAX ? CNT_MAX : i + 1);
      end
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_ext();
    logic [CODE_W-1:0] want_code;
    logic want_ill;
`ifdef DECODE_EXT_INSTR_EN
    want_code = '0; want_code[32] = 1'b1; want_ill = 1'b0;
`else
    want_code = '0; want_ill = 1'b1;
`endif
    cyc(1'b1, 32'h00220018, 32'h700, 1'b0, 1'b0);
    n_chk++;
    if (out_code !== want_code || out_illegal !== want_ill) begin
      n_fail++; $display("FAIL mult got code=%h ill=%b want code=%h ill=%b", out_code, out_illegal, want_code, want_ill);
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      ent_t h;
      h = head_m();
      n_chk++;
      if ({out_valid, in_ready, out_code, out_illegal, out_instr, out_pc, illegal_cnt} !==
          {q.size() != 0, q.size() < DEPTH, h.code, h.ill, h.instr, h.pc, CNT_W'(m_cnt)}) begin
        n_fail++;
        $display("FAIL random[%0d] got v=%b rdy=%b code=%h ill=%b instr=%h pc=%h cnt=%0d want v=%b rdy=%b code=%h ill=%b instr=%h pc=%h cnt=%0d",
                 k, out_valid, in_ready, out_code, out_illegal, out_instr, out_pc, illegal_cnt,
                 q.size() != 0, q.size() < DEPTH, h.code, h.ill, h.instr, h.pc, m_cnt);
      end
      cyc($urandom_range(0, 9) < 7, rnd_word(), $urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lui_illegal();
    test_fill();
    test_flush();
    test_async_rst();
    test_saturate();
    test_ext();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
